// File: rtl/traffic_scheduler.sv
// traffic_scheduler: owns the game level and issues per-lane move ticks,
// freezing traffic after a collision and speeding it up on level-up.
module traffic_scheduler #(
  parameter int unsigned c_NUM_LANES     = 4,
  parameter int unsigned c_BASE_PERIOD   = 1650000,
  parameter int unsigned c_PERIOD_STEP   = 150000,
  parameter int unsigned c_MIN_PERIOD    = 300000,
  parameter int unsigned c_LANE_OFFSET   = 100000,
  parameter int unsigned c_MAX_LEVEL     = 7,
  parameter int unsigned c_FREEZE_CYCLES = 25000000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Game_Active,
  input  logic                   i_Level_Up,
  input  logic                   i_Collision,
  output logic [c_NUM_LANES-1:0] o_Lane_Tick,
  output logic [2:0]             o_Level,
  output logic [31:0]            o_Period,
  output logic                   o_Frozen,
  output logic [1:0]             o_State
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FREEZE = 2'd2, LEVEL_UP = 2'd3} state_t;
  state_t                 state_q, state_d;
  logic [2:0]             level_q, level_d;
  logic [31:0]            period_q, period_d, frz_q, frz_d, step_amt;
  logic [31:0]            cnt_q [c_NUM_LANES];
  logic [31:0]            cnt_d [c_NUM_LANES];
  logic [c_NUM_LANES-1:0] tick_q, tick_d, lane_last;
  logic                   run_go, frz_done;
  always_comb begin
    for (int i = 0; i < c_NUM_LANES; i++)
      lane_last[i] = cnt_q[i] == period_q + 32'(i) * c_LANE_OFFSET - 32'd1;
  end
  // Counters only advance on clean RUN cycles, so a pulse cycle never loses a tick.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    frz_d    = frz_q;
    cnt_d    = cnt_q;
    tick_d   = '0;
    run_go   = state_q == RUN && !i_Collision && !i_Level_Up;
    frz_done = frz_q == c_FREEZE_CYCLES - 1;
    if (!i_Game_Active) begin
      state_d = IDLE;
      level_d = '0;
      frz_d   = '0;
      for (int i = 0; i < c_NUM_LANES; i++) cnt_d[i] = '0;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: state_d = i_Collision ? FREEZE : i_Level_Up ? LEVEL_UP : RUN;
        FREEZE: begin
          state_d = frz_done ? RUN : FREEZE;
          frz_d   = frz_done ? '0 : frz_q + 32'd1;
        end
        default: begin
          state_d = RUN;
          level_d = level_q == 3'(c_MAX_LEVEL) ? level_q : level_q + 3'd1;
          for (int i = 0; i < c_NUM_LANES; i++) cnt_d[i] = '0;
        end
      endcase
      if (run_go) begin
        for (int i = 0; i < c_NUM_LANES; i++) begin
          cnt_d[i]  = lane_last[i] ? '0 : cnt_q[i] + 32'd1;
          tick_d[i] = lane_last[i];
        end
      end
    end
    step_amt = 32'(level_d) * c_PERIOD_STEP;
    period_d = step_amt + c_MIN_PERIOD >= c_BASE_PERIOD ? c_MIN_PERIOD : c_BASE_PERIOD - step_amt;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      level_q  <= '0;
      period_q <= c_BASE_PERIOD;
      frz_q    <= '0;
      tick_q   <= '0;
      for (int i = 0; i < c_NUM_LANES; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      period_q <= period_d;
      frz_q    <= frz_d;
      tick_q   <= tick_d;
      cnt_q    <= cnt_d;
    end
  end
  assign o_Lane_Tick = tick_q;
  assign o_Level     = level_q;
  assign o_Period    = period_q;
  assign o_Frozen    = state_q == FREEZE;
  assign o_State     = state_q;
endmodule

// File: tb/tb_traffic_scheduler.sv
// tb_traffic_scheduler: vector table, directed corner sequences and random
// stimulus, all checked against a behavioural lane-schedule model.
module tb_traffic_scheduler;
  localparam int BASE = 20, STEP = 4, MINP = 8, OFF = 2, MAXL = 7, FRZ = 10;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, ga = 1'b0, lu = 1'b0, col = 1'b0;
  logic [3:0]  tick;
  logic [2:0]  level;
  logic [31:0] period;
  logic        frozen;
  logic [1:0]  st;
  int checks = 0, passed = 0, frozen_seen = 0;
  int m_mode = 0, m_level = 0, m_frz = 0;
  int m_el[4] = '{default: 0};
  logic [3:0] m_tick = '0;
  int t1[4], t2[4];
  int n;
  typedef struct {
    logic rst, ga, lu, col;
    int st, lvl, per, frz;
  } vec_t;
  vec_t vt[10];

  traffic_scheduler #(
    .c_NUM_LANES(4), .c_BASE_PERIOD(BASE), .c_PERIOD_STEP(STEP), .c_MIN_PERIOD(MINP),
    .c_LANE_OFFSET(OFF), .c_MAX_LEVEL(MAXL), .c_FREEZE_CYCLES(FRZ)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Game_Active(ga), .i_Level_Up(lu), .i_Collision(col),
    .o_Lane_Tick(tick), .o_Level(level), .o_Period(period), .o_Frozen(frozen), .o_State(st)
  );

  function automatic int lvl_period(int l);
    return (BASE - l * STEP > MINP) ? BASE - l * STEP : MINP;
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Lane i has run m_el[i] clean RUN cycles since its phase was cleared; it ticks
  // whenever that count reaches a whole multiple of its lane period.
  function void model_step();
    m_tick = '0;
    if (rst || !ga) begin
      m_mode = 0; m_level = 0; m_frz = 0; m_el = '{default: 0};
    end else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (col) begin m_mode = 2; m_frz = FRZ; end
      else if (lu) m_mode = 3;
      else for (int i = 0; i < 4; i++) begin
        m_el[i]++;
        if (m_el[i] % (lvl_period(m_level) + i * OFF) == 0) m_tick[i] = 1'b1;
      end
    end else if (m_mode == 2) begin
      m_frz--;
      if (m_frz == 0) m_mode = 1;
    end else begin
      m_level = m_level < MAXL ? m_level + 1 : MAXL;
      m_el = '{default: 0};
      m_mode = 1;
    end
  endfunction

  task automatic step(logic r, logic g, logic l, logic c);
    rst = r; ga = g; lu = l; col = c;
    @(posedge clk);
    model_step();
    #1;
    check("state", st, m_mode);
    check("level", level, m_level);
    check("period", period, lvl_period(m_level));
    check("frozen", frozen, m_mode == 2);
    check("tick", tick, m_tick);
    if (frozen) frozen_seen++;
  endtask

  task automatic run_record(int cyc);
    t1 = '{default: -1}; t2 = '{default: -1};
    for (int k = 1; k <= cyc; k++) begin
      step(0, 1, 0, 0);
      for (int i = 0; i < 4; i++)
        if (tick[i]) begin
          if (t1[i] < 0) t1[i] = k;
          else if (t2[i] < 0) t2[i] = k;
        end
    end
  endtask

  task automatic wait_tick(int lane, int budget, output int cnt);
    cnt = -1;
    for (int k = 1; k <= budget; k++) begin
      step(0, 1, 0, 0);
      if (tick[lane]) begin cnt = k; break; end
    end
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 20, 0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 20, 0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 0, 20, 0};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 16, 0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1, 16, 1};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 1, 16, 1};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 20, 0};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 20, 0};
    vt[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 20, 1};
    vt[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 20, 0};
    for (int k = 0; k < 10; k++) begin
      step(vt[k].rst, vt[k].ga, vt[k].lu, vt[k].col);
      check($sformatf("vec%0d_state", k), st, vt[k].st);
      check($sformatf("vec%0d_level", k), level, vt[k].lvl);
      check($sformatf("vec%0d_period", k), period, vt[k].per);
      check($sformatf("vec%0d_frozen", k), frozen, vt[k].frz);
      check($sformatf("vec%0d_tick", k), tick, 0);
    end
    step(0, 1, 0, 0);
    check("run_entry", st, 1);
    run_record(60);
    check("lane0_first", t1[0], 20);
    check("lane0_second", t2[0], 40);
    check("lane1_first", t1[1], 22);
    check("lane2_first", t1[2], 24);
    check("lane3_first", t1[3], 26);
    check("lane3_second", t2[3], 52);
    for (int k = 0; k < 4; k++) begin step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 0, 0); end
    check("lvl4_level", level, 4);
    check("lvl4_period", period, 8);
    run_record(30);
    check("lvl4_lane1_gap", t2[1] - t1[1], 10);
    for (int k = 0; k < 8; k++) begin step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 0, 0); end
    check("lvl_sat", level, 7);
    wait_tick(0, 20, n);
    check("freeze_sync", n > 0, 1);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
    frozen_seen = 0;
    step(0, 1, 0, 1);
    wait_tick(0, 50, n);
    check("freeze_gap", 4 + n, lvl_period(7) + 1 + FRZ);
    check("freeze_len", frozen_seen, FRZ);
    step(0, 0, 0, 0);
    check("drop_idle", st, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 0, 0); end
    check("lvl3", level, 3);
    step(0, 1, 1, 1);
    check("colup_state", st, 2);
    check("colup_level", level, 3);
    step(0, 1, 1, 0);
    check("frz_lu_state", st, 2);
    check("frz_lu_level", level, 3);
    for (int k = 0; k < 12; k++) step(0, 1, 0, 0);
    check("frz_exit_state", st, 1);
    check("frz_exit_level", level, 3);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("ga_drop_state", st, 0);
    check("ga_drop_level", level, 0);
    check("ga_drop_period", period, 20);
    check("ga_drop_tick", tick, 0);
    step(0, 1, 0, 0);
    wait_tick(0, 40, n);
    check("rerun_lane0_first", n, 20);
    step(0, 1, 1, 0); step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
    check("pre_rst_frozen", frozen, 1);
    step(1, 1, 0, 0);
    check("rst_frz_state", st, 0);
    check("rst_frz_frozen", frozen, 0);
    check("rst_frz_level", level, 0);
    check("rst_frz_period", period, 20);
    check("rst_frz_tick", tick, 0);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 199) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
